// File: rtl/score_display.sv
// score_display: 0..63 score to two BCD digits shown on a scanned 7-seg display.
// Optional collision blink is compiled in when SCORE_BLINK_EN is defined.
module score_display #(
  parameter int REFRESH_BITS = 18,
  parameter int BLINK_BITS   = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] score,
  input  logic       colision,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [5:0]  latched, latched_n;
  logic [13:0] sr, sr_n;
  logic [2:0]  cnt, cnt_n;
  logic        busy_n;
  logic        dirty, dirty_n;
  logic [3:0]  ones, ones_n;
  logic [3:0]  tens, tens_n;

  logic [REFRESH_BITS-1:0] scan;
  logic [1:0]              sel;
  logic [3:0]              an_n;
  logic [6:0]              seg_n;

  // one double-dabble step: correct nibbles >= 5, then shift left
  function automatic logic [13:0] dabble(input logic [13:0] v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = v[13:10];
    lo = v[9:6];
    if (lo >= 4'd5) lo = lo + 4'd3;
    if (hi >= 4'd5) hi = hi + 4'd3;
    return {hi[2:0], lo, v[5:0], 1'b0};
  endfunction

  // active-low segment pattern {g,f,e,d,c,b,a} for a BCD digit
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // converter state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      latched <= 6'd0;
      sr      <= 14'd0;
      cnt     <= 3'd0;
      busy    <= 1'b0;
      dirty   <= 1'b1;
      ones    <= 4'd0;
      tens    <= 4'd0;
    end else begin
      state   <= state_n;
      latched <= latched_n;
      sr      <= sr_n;
      cnt     <= cnt_n;
      busy    <= busy_n;
      dirty   <= dirty_n;
      ones    <= ones_n;
      tens    <= tens_n;
    end
  end

  // converter next-state: latch, six dabble steps, publish digits
  always_comb begin
    state_n   = state;
    latched_n = latched;
    sr_n      = sr;
    cnt_n     = cnt;
    busy_n    = busy;
    dirty_n   = dirty;
    ones_n    = ones;
    tens_n    = tens;
    case (state)
      IDLE: begin
        if (dirty || (score != latched)) begin
          latched_n = score;
          sr_n      = {8'd0, score};
          cnt_n     = 3'd6;
          busy_n    = 1'b1;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        sr_n  = dabble(sr);
        cnt_n = cnt - 3'd1;
        if (cnt == 3'd1) state_n = DONE;
      end
      DONE: begin
        ones_n  = sr[9:6];
        tens_n  = sr[13:10];
        busy_n  = 1'b0;
        dirty_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // free-running digit scan counter
  always_ff @(posedge clk) begin
    if (reset) scan <= '0;
    else       scan <= scan + 1'b1;
  end

  assign sel = scan[REFRESH_BITS-1 -: 2];

`ifdef SCORE_BLINK_EN
  logic [BLINK_BITS-1:0] blink;

  // free-running blink counter; its MSB gates the display off
  always_ff @(posedge clk) begin
    if (reset) blink <= '0;
    else       blink <= blink + 1'b1;
  end
`else
  logic unused_colision;
  localparam int unused_blink_bits = BLINK_BITS;
  assign unused_colision = colision;
`endif

  // digit select, leading-zero blanking and optional blink
  always_comb begin
    an_n  = 4'b1111;
    seg_n = 7'h7F;
    case (sel)
      2'd0: begin
        an_n  = 4'b1110;
        seg_n = enc(ones);
      end
      2'd1: begin
        if (tens != 4'd0) begin
          an_n  = 4'b1101;
          seg_n = enc(tens);
        end
      end
      default: begin
        an_n  = 4'b1111;
        seg_n = 7'h7F;
      end
    endcase
`ifdef SCORE_BLINK_EN
    if (colision && blink[BLINK_BITS-1]) an_n = 4'b1111;
`endif
  end

  // registered display drive, decimal point always off
  always_ff @(posedge clk) begin
    if (reset) begin
      an   <= 4'b1111;
      sseg <= 8'hFF;
    end else begin
      an   <= an_n;
      sseg <= {1'b1, seg_n};
    end
  end

endmodule
